mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word address width of the shared memory.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, number of consecutive fetch denials before fetch is forced.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req  in  1  instruction-fetch read request, held until granted.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch word address.
REQ-008 SHALL have port if_gnt  out  1  fetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid  out  1  fetch read data valid.
REQ-010 SHALL have port if_rdata  out  DATA_W  fetch read data.
REQ-011 SHALL have port d_req  in  1  load/store request, held until granted.
REQ-012 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  in  ADDR_W  data word address.
REQ-014 SHALL have port d_wdata  in  DATA_W  store data.
REQ-015 SHALL have port d_gnt  out  1  data request accepted this cycle.
REQ-016 SHALL have port d_rvalid  out  1  load data valid.
REQ-017 SHALL have port d_rdata  out  DATA_W  load data.
REQ-018 SHALL have port mem_en, mem_we  out  1 each  single-port memory enable and write enable.
REQ-019 SHALL have port mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  (1-cycle synchronous read memory).
REQ-020 SHALL have port fetch_stall  out  1  high when if_req=1 and if_gnt=0.

Function
REQ-021 Grants are combinational from current inputs and registered state; at most one of if_gnt, d_gnt is high per cycle.
REQ-022 Default priority: data over fetch; if only one requester, it is granted.
REQ-023 Starve counter (width clog2(STARVE_MAX+1)) increments when if_req=1 and if_gnt=0, saturates at STARVE_MAX, clears on if_gnt or if_req=0.
REQ-024 When counter == STARVE_MAX and both request, fetch is granted instead of data.
REQ-025 On a grant: mem_en=1, mem_addr/mem_we/mem_wdata driven from the grantee in the same cycle; fetch grants force mem_we=0.
REQ-026 With no grant: mem_en=0, mem_we=0; mem_addr and mem_wdata don't-care but held at 0.
REQ-027 Read owner register {NONE, IF, D} captures the grantee of each read grant; stores set it to NONE.
REQ-028 Cycle after a read grant: the owner's rvalid=1 for exactly one cycle, its rdata = mem_rdata; the other rvalid=0.
REQ-029 rdata outputs equal mem_rdata when their rvalid=0 (values not qualified).
REQ-030 Back-to-back grants every cycle are supported; throughput one access per cycle; read latency exactly 1 cycle from grant.
REQ-031 Stores generate no rvalid; store completes at its grant edge.
REQ-032 Request dropped before grant is legal; no state is retained for it.

Reset
REQ-033 While reset=1: if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, fetch_stall all 0; starve counter 0; owner NONE.
REQ-034 Reset asserted mid-read discards the pending response: no rvalid in the cycle after reset deasserts.
REQ-035 The first grant is possible in the first cycle with reset=0.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the owner enum (NONE/IF/D) and the default ADDR_W, DATA_W, and STARVE_MAX constants.
REQ-037 One sub-module arb_starve_ctr (saturating counter, inputs inc/clr, output at_max) is natural; the rest is flat.

Verification
REQ-038 Fetch only, if_addr=0x004, mem_rdata=0x00A00093 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x00A00093.
REQ-039 Both request, d_we=0, d_addr=0x100 -> d_gnt=1, if_gnt=0, fetch_stall=1; next cycle d_rvalid=1 only.
REQ-040 d_req held high 6 cycles with if_req high, STARVE_MAX=4 -> d_gnt cycles 1-4, if_gnt cycle 5, d_gnt cycle 6.
REQ-041 Store d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x3FF same cycle; no rvalid following.
REQ-042 Reset pulsed in the cycle after a fetch grant -> if_rvalid stays 0 and the counter is 0 after reset.
REQ-043 Alternating load/fetch every cycle for 20 cycles -> every rvalid is routed to the correct owner, exactly 1 cycle after its grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Which requester owns the read response that returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive fetch denials; at_max forces the next fetch grant.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  assign at_max = (cnt_q == CNT_W'(MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous memory between instruction fetch and load/store,
// data-first with a starvation override for fetch; routes 1-cycle read data to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_stall
);

  logic   starve_at_max;
  logic   starve_inc;
  logic   starve_clr;
  owner_e owner_q;
  owner_e owner_d;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // Grant selection, memory port muxing and next read owner.
  always_comb begin
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    owner_d     = OWN_NONE;

    if (!reset) begin
      if (if_req && (!d_req || starve_at_max)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      owner_d   = d_we ? OWN_NONE : OWN_D;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      owner_d   = OWN_IF;
    end
  end

  assign fetch_stall = if_req && !if_gnt && !reset;
  assign starve_inc  = if_req && !if_gnt;
  assign starve_clr  = if_gnt || !if_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Reset gating keeps a response that was in flight at reset from escaping.
  assign if_rvalid = !reset && (owner_q == OWN_IF);
  assign d_rvalid  = !reset && (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule
